// File: rtl/fifo2axis.sv
// fifo2axis: collects words from a write-strobe source into a small burst
// buffer, then replays the burst as an AXI-Stream master with one tlast per
// burst.
//
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   din, wr_en      - write port; din captured when wr_en=1 and full=0
//   flush           - close a partial burst and stream the words held so far
//   full            - buffer closed to writes (STREAM or DONE)
//   overflow        - one-cycle pulse after a write arrived while full
//   tdata, tvalid,
//   tlast, tready   - AXI-Stream master interface
//   done            - one-cycle pulse after the tlast handshake
module fifo2axis #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  input  logic                  flush,
  output logic                  full,
  output logic                  overflow,
  output logic [DATA_WIDTH-1:0] tdata,
  output logic                  tvalid,
  output logic                  tlast,
  input  logic                  tready,
  output logic                  done
);

  localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);
  localparam int unsigned IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned DEPTH = 2 ** IDX_W;
  localparam logic [CNT_W-1:0] LEN_FULL = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        len_q, len_d;
  logic [CNT_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic                    tvalid_q, tvalid_d;
  logic                    tlast_q, tlast_d;
  logic                    done_q, done_d;
  logic                    ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    wr_fire_c;
  logic [IDX_W-1:0]        wr_idx_c;
  logic                    start_c;
  logic [CNT_W-1:0]        cnt_inc_c;

  // Writes are closed while a burst is streaming or retiring.
  assign full     = (state_q == STREAM) || (state_q == DONE);
  assign overflow = ovf_q;
  assign tdata    = tdata_q;
  assign tvalid   = tvalid_q;
  assign tlast    = tlast_q;
  assign done     = done_q;

  assign cnt_inc_c = cnt_q + ONE;

  // State register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      rd_ptr_q <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      rd_ptr_q <= rd_ptr_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  // Burst buffer; contents are qualified by cnt/len so no reset is needed.
  always_ff @(posedge clk) begin
    if (wr_fire_c) begin
      mem_q[wr_idx_c] <= din;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    rd_ptr_d  = rd_ptr_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    done_d    = 1'b0;
    ovf_d     = 1'b0;
    wr_fire_c = 1'b0;
    wr_idx_c  = IDX_W'(cnt_q);
    start_c   = 1'b0;

    case (state_q)
      IDLE: begin
        // A lone flush here is ignored: there is nothing to stream.
        if (wr_en) begin
          wr_fire_c = 1'b1;
          wr_idx_c  = '0;
          cnt_d     = ONE;
          if ((BURST_LEN == 1) || flush) begin
            start_c = 1'b1;
            len_d   = ONE;
          end else begin
            state_d = LOAD;
          end
        end
      end

      LOAD: begin
        if (wr_en) begin
          wr_fire_c = 1'b1;
          cnt_d     = cnt_inc_c;
          if ((cnt_inc_c == LEN_FULL) || flush) begin
            start_c = 1'b1;
            len_d   = cnt_inc_c;
          end
        end else if (flush) begin
          start_c = 1'b1;
          len_d   = cnt_q;
        end
      end

      STREAM: begin
        if (tvalid_q && tready) begin
          if (tlast_q) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            done_d   = 1'b1;
            state_d  = DONE;
          end else begin
            rd_ptr_d = rd_ptr_q + ONE;
            tdata_d  = mem_q[IDX_W'(rd_ptr_q + ONE)];
            tlast_d  = (CNT_W'(rd_ptr_q + CNT_W'(2)) == len_q);
          end
        end
      end

      DONE: begin
        cnt_d    = '0;
        len_d    = '0;
        rd_ptr_d = '0;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Stream entry: the first word may be the one being written this edge.
    if (start_c) begin
      state_d  = STREAM;
      tvalid_d = 1'b1;
      rd_ptr_d = '0;
      tlast_d  = (len_d == ONE);
      tdata_d  = (wr_fire_c && (wr_idx_c == '0)) ? din : mem_q[0];
    end

    if (wr_en && full) begin
      ovf_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo2axis.sv
// Self-checking bench for fifo2axis: a scoreboard queue holds the beats each
// accepted write should produce; a negedge monitor pops and compares them.
module tb_fifo2axis;

  localparam int unsigned DW = 32;
  localparam int unsigned BL = 4;

  logic          clk;
  logic          rst;
  logic [DW-1:0] din;
  logic          wr_en;
  logic          flush;
  logic          full;
  logic          overflow;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic          tready;
  logic          done;

  fifo2axis #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .wr_en    (wr_en),
    .flush    (flush),
    .full     (full),
    .overflow (overflow),
    .tdata    (tdata),
    .tvalid   (tvalid),
    .tlast    (tlast),
    .tready   (tready),
    .done     (done)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    beats    = 0;
  int    mdl_cnt  = 0;
  logic  done_exp = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one write; acc says whether the model expects it to be accepted.
  task automatic wr(input logic [DW-1:0] d, input logic fl, input logic acc);
    beat_t b;
    wr_en = 1'b1;
    din   = d;
    flush = fl;
    if (acc) begin
      mdl_cnt++;
      b.data = d;
      b.last = (mdl_cnt == BL) || fl;
      if (b.last) mdl_cnt = 0;
      exp_q.push_back(b);
    end
    tick();
    wr_en = 1'b0;
    flush = 1'b0;
  endtask

  task automatic flush_only();
    beat_t b;
    flush = 1'b1;
    if (mdl_cnt > 0) begin
      b = exp_q.pop_back();
      b.last = 1'b1;
      exp_q.push_back(b);
      mdl_cnt = 0;
    end
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 50) begin
      tick();
      n++;
    end
    check_eq("done_seen", 32'(done), 32'd1);
  endtask

  // Monitor: handshake decided by values stable at the negedge.
  always @(negedge clk) begin
    if (rst) begin
      done_exp = 1'b0;
    end else begin
      check_eq("done", 32'(done), 32'(done_exp));
      done_exp = 1'b0;
      if (tvalid && tready) begin
        beats++;
        check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          beat_t b;
          b = exp_q.pop_front();
          check_eq("tdata", tdata, b.data);
          check_eq("tlast", 32'(tlast), 32'(b.last));
          if (b.last) done_exp = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int b0;
    rst    = 1'b1;
    din    = '0;
    wr_en  = 1'b0;
    flush  = 1'b0;
    tready = 1'b0;
    #12;
    check_eq("rst_tvalid", 32'(tvalid), 32'd0);
    check_eq("rst_tlast", 32'(tlast), 32'd0);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    check_eq("rst_tdata", tdata, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // 1: full burst, tready always high
    tready = 1'b1;
    b0 = beats;
    for (int i = 0; i < 4; i++) wr(32'hA0 + 32'(i), 1'b0, 1'b1);
    check_eq("t1_tvalid", 32'(tvalid), 32'd1);
    check_eq("t1_tdata0", tdata, 32'hA0);
    check_eq("t1_full", 32'(full), 32'd1);
    wait_done(n);
    check_eq("t1_latency", 32'(n), 32'd4);
    check_eq("t1_full_done", 32'(full), 32'd1);
    check_eq("t1_tvalid_done", 32'(tvalid), 32'd0);
    tick();
    check_eq("t1_full_idle", 32'(full), 32'd0);
    check_eq("t1_beats", 32'(beats - b0), 32'd4);

    // 2: backpressure on the second word
    b0 = beats;
    for (int i = 0; i < 4; i++) wr(32'hA0 + 32'(i), 1'b0, 1'b1);
    tick();
    tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("t2_hold_data", tdata, 32'hA1);
      check_eq("t2_hold_valid", 32'(tvalid), 32'd1);
      tick();
    end
    check_eq("t2_hold_data4", tdata, 32'hA1);
    tready = 1'b1;
    wait_done(n);
    check_eq("t2_latency", 32'(n), 32'd3);
    tick();
    check_eq("t2_beats", 32'(beats - b0), 32'd4);

    // 3: partial burst closed by a lone flush
    b0 = beats;
    wr(32'h11, 1'b0, 1'b1);
    wr(32'h22, 1'b0, 1'b1);
    check_eq("t3_no_stream", 32'(tvalid), 32'd0);
    flush_only();
    check_eq("t3_tdata0", tdata, 32'h11);
    check_eq("t3_tlast0", 32'(tlast), 32'd0);
    wait_done(n);
    check_eq("t3_latency", 32'(n), 32'd2);
    tick();
    check_eq("t3_beats", 32'(beats - b0), 32'd2);

    // 4: flush together with a write keeps the word
    b0 = beats;
    wr(32'h55, 1'b0, 1'b1);
    wr(32'h66, 1'b1, 1'b1);
    check_eq("t4_tdata0", tdata, 32'h55);
    wait_done(n);
    check_eq("t4_latency", 32'(n), 32'd2);
    tick();
    check_eq("t4_beats", 32'(beats - b0), 32'd2);

    // 5: write while streaming is dropped and flagged
    b0 = beats;
    tready = 1'b0;
    for (int i = 0; i < 4; i++) wr(32'hC0 + 32'(i), 1'b0, 1'b1);
    check_eq("t5_ovf_pre", 32'(overflow), 32'd0);
    wr(32'hFF, 1'b0, 1'b0);
    check_eq("t5_ovf", 32'(overflow), 32'd1);
    tick();
    check_eq("t5_ovf_clr", 32'(overflow), 32'd0);
    check_eq("t5_tdata", tdata, 32'hC0);
    tready = 1'b1;
    wait_done(n);
    check_eq("t5_latency", 32'(n), 32'd4);
    tick();
    for (int i = 0; i < 4; i++) wr(32'hD0 + 32'(i), 1'b0, 1'b1);
    check_eq("t5_next_tdata", tdata, 32'hD0);
    wait_done(n);
    tick();
    check_eq("t5_beats", 32'(beats - b0), 32'd8);

    // 6: asynchronous reset mid-stream
    b0 = beats;
    for (int i = 0; i < 4; i++) wr(32'hA0 + 32'(i), 1'b0, 1'b1);
    tick();
    tick();
    tready = 1'b0;
    check_eq("t6_tdata_a2", tdata, 32'hA2);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t6_rst_tvalid", 32'(tvalid), 32'd0);
    check_eq("t6_rst_tlast", 32'(tlast), 32'd0);
    check_eq("t6_rst_full", 32'(full), 32'd0);
    exp_q.delete();
    mdl_cnt = 0;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    tready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) wr(32'hB0 + 32'(i), 1'b0, 1'b1);
    check_eq("t6_tdata_b0", tdata, 32'hB0);
    wait_done(n);
    check_eq("t6_latency", 32'(n), 32'd4);
    tick();
    check_eq("t6_beats", 32'(beats - b0), 32'd6);

    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo2axis.md
Name: fifo2axis

Overview:
- Transmit-side counterpart of the result collector: gathers words from a simple write-strobe source into a small internal burst buffer.
- Replays the burst as an AXI-Stream master (tdata/tvalid/tready/tlast), with one tlast per burst.
- Sits between the host/accelerator input staging and the compute core's AXI-Stream slave input.

Parameters:
- DATA_WIDTH, 32: width of din and tdata.
- BURST_LEN, 4: words per full burst and internal buffer depth. Legal range 1..16.
- CNT_W, $clog2(BURST_LEN+1): width of internal word counter and length register. Derived; not overridden.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  DATA_WIDTH  word to load.
- wr_en  input  1  write strobe; din is captured on a clock edge with wr_en=1 and full=0.
- flush  input  1  close a partial burst early and stream the words held so far.
- full  output  1  buffer is closed to writes (streaming in progress).
- overflow  output  1  one-cycle pulse: wr_en arrived while full=1; that word is dropped.
- tdata  output  DATA_WIDTH  AXI-Stream data.
- tvalid  output  1  AXI-Stream valid.
- tlast  output  1  AXI-Stream last, high with the final word of each burst only.
- tready  input  1  AXI-Stream ready from downstream.
- done  output  1  one-cycle pulse after the tlast handshake completes.

Behaviour:
- States: IDLE=0, LOAD=1, STREAM=2, DONE=3 (2-bit state register).
- Reset (async, immediate): state=IDLE; cnt=0; len=0; rd_ptr=0; tvalid=0; tlast=0; tdata=0; done=0; overflow=0. full is low in IDLE. Reset during LOAD or STREAM discards the buffer; the next burst starts from word 0.
- full = 1 exactly when state is STREAM or DONE. It is decoded from the state register, with no combinational path from inputs.
- IDLE:
  - wr_en writes buffer[0] and sets cnt=1.
  - Next state is STREAM if BURST_LEN==1 or flush=1 in the same cycle; otherwise LOAD.
  - flush without wr_en in IDLE is ignored (no zero-length bursts).
- LOAD:
  - wr_en writes buffer[cnt] and increments cnt.
  - The write that makes cnt==BURST_LEN moves to STREAM with len=BURST_LEN.
  - flush moves to STREAM with len=cnt, or len=cnt+1 if wr_en is high in the same cycle (the word is kept).
  - Idle cycles with no strobe hold state.
- Entry to STREAM, registered, first word visible the cycle after the closing write/flush edge: tvalid=1, tdata=buffer[0], rd_ptr=0, tlast=(len==1).
- STREAM:
  - AXI rule: while tvalid=1 and tready=0, tdata and tlast are held stable and tvalid is never dropped.
  - On a handshake (tvalid and tready) with tlast=0: rd_ptr+1, tdata=buffer[rd_ptr+1], tlast=(rd_ptr+2==len). Full throughput is one word per cycle.
  - On a handshake with tlast=1: tvalid=0, tlast=0, go to DONE.
  - tvalid never depends combinationally on tready.
- DONE, exactly one cycle: done=1; cnt, len and rd_ptr cleared; next state IDLE. full drops when IDLE is entered.
- wr_en while full=1: word ignored; overflow=1 on the next cycle for one cycle. Buffer contents and the stream are unaffected.
- flush while full=1: ignored.
- tready while tvalid=0: ignored.
- Burst-to-burst: the minimum gap between the tlast handshake and the first accepted write of the next burst is 2 cycles (DONE, then IDLE accepts).
- Widths: cnt, len and rd_ptr are CNT_W bits. No wrap is possible because cnt saturates at BURST_LEN by the state transition.

Test Plan:
1. Full burst: BURST_LEN=4, write 0xA0,0xA1,0xA2,0xA3 on consecutive cycles, tready=1 -> tvalid rises the cycle after the 0xA3 write; tdata A0..A3 on 4 consecutive cycles; tlast only with A3; done pulses the next cycle; full high from first tvalid cycle through the DONE cycle.
2. Backpressure: as test 1, drop tready for 3 cycles while tdata=0xA1 -> tdata stays 0xA1 and tvalid stays 1 for 4 cycles; A2 and A3 follow; exactly 4 handshakes in total.
3. Partial flush: write 0x11 and 0x22, then flush alone -> 2-word stream 0x11, 0x22 with tlast on 0x22; done pulses once.
4. Flush with write: write 0x55, then wr_en=1 (din=0x66) together with flush -> stream 0x55, 0x66 with tlast on 0x66.
5. Overflow: during streaming, pulse wr_en with din=0xFF -> overflow=1 for one cycle; 0xFF never appears on tdata; next burst loads normally after done.
6. Async reset mid-stream: assert rst between clock edges while tdata=0xA2 -> tvalid, tlast and full go 0 immediately; after release, write 0xB0..0xB3 -> stream starts at 0xB0.
